// File: rtl/td4_prog_loader.sv
// td4_prog_loader: program store for the 4-bit CPU, loaded by a host byte stream and gating CPU reset.
module td4_prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [AW-1:0] addr,
  output logic [3:0]    opecode,
  output logic [3:0]    imm,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          run_req,
  input  logic          reload_req,
  output logic          cpu_rst,
  output logic [AW:0]   prog_len,
  output logic          running
);
  typedef enum logic [1:0] {LOAD, ARMED, RUN} state_t;
  localparam logic [AW:0] last_idx = (AW+1)'(DEPTH - 1);
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic acc;
  assign acc = ld_valid & (state == LOAD);
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state <= LOAD;
      wptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (acc) begin
        mem[wptr[AW-1:0]] <= ld_data;
        wptr <= wptr + 1'b1;
      end
      if (state != LOAD && reload_req) begin
        state <= LOAD;
        wptr <= '0;
      end else if (state == LOAD)
        state <= run_req ? RUN : (acc && (ld_last || wptr == last_idx)) ? ARMED : LOAD;
      else if (state == ARMED && run_req)
        state <= RUN;
    end
  end
  assign ld_ready = state == LOAD;
  assign running = state == RUN;
  assign cpu_rst = state != RUN;
  assign prog_len = wptr;
  assign opecode = running ? mem[addr][7:4] : 4'h0;
  assign imm = running ? mem[addr][3:0] : 4'h0;
endmodule

// File: tb/tb_td4_prog_loader.sv
// tb_td4_prog_loader: directed scenario tests for the program loader.
module tb_td4_prog_loader;
  logic clk = 0;
  logic n_rst = 1;
  logic [3:0] addr = 0;
  logic [3:0] opecode, imm;
  logic ld_valid = 0, ld_last = 0, run_req = 0, reload_req = 0;
  logic [7:0] ld_data = 0;
  logic ld_ready, cpu_rst, running;
  logic [4:0] prog_len;
  int passed = 0, total = 0;

  td4_prog_loader dut (
    .clk(clk), .n_rst(n_rst), .addr(addr), .opecode(opecode), .imm(imm),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .run_req(run_req), .reload_req(reload_req), .cpu_rst(cpu_rst),
    .prog_len(prog_len), .running(running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1;
    step();
    step();
    total++;
    if ({cpu_rst, ld_ready, running, prog_len} !== {1'b1, 1'b1, 1'b0, 5'd0})
      $display("FAIL reset_ctl: got cpu_rst/ld_ready/running/len=%b/%b/%b/%0d want 1/1/0/0", cpu_rst, ld_ready, running, prog_len);
    else passed++;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1;
      total++;
      if ({opecode, imm} !== 8'h00) $display("FAIL reset_fetch[%0d]: got %h want 00", a, {opecode, imm});
      else passed++;
    end
    n_rst = 0;
    step();
    total++;
    if ({cpu_rst, ld_ready, prog_len} !== {1'b1, 1'b1, 5'd0})
      $display("FAIL post_reset: got cpu_rst/ld_ready/len=%b/%b/%0d want 1/1/0", cpu_rst, ld_ready, prog_len);
    else passed++;
  endtask

  task automatic test_short_load();
    ld_valid = 1; ld_data = 8'h13;
    step();
    ld_data = 8'h25; ld_last = 1;
    step();
    ld_valid = 0; ld_last = 0;
    total++;
    if ({ld_ready, cpu_rst, prog_len} !== {1'b0, 1'b1, 5'd2})
      $display("FAIL short_armed: got ld_ready/cpu_rst/len=%b/%b/%0d want 0/1/2", ld_ready, cpu_rst, prog_len);
    else passed++;
    run_req = 1;
    step();
    run_req = 0;
    total++;
    if ({cpu_rst, running} !== 2'b01) $display("FAIL short_run: got cpu_rst/running=%b/%b want 0/1", cpu_rst, running);
    else passed++;
    addr = 0; #1;
    total++;
    if ({opecode, imm} !== 8'h13) $display("FAIL short_fetch0: got %h want 13", {opecode, imm});
    else passed++;
    addr = 1; #1;
    total++;
    if ({opecode, imm} !== 8'h25) $display("FAIL short_fetch1: got %h want 25", {opecode, imm});
    else passed++;
    addr = 2; #1;
    total++;
    if ({opecode, imm} !== 8'h00) $display("FAIL short_fetch2: got %h want 00", {opecode, imm});
    else passed++;
  endtask

  task automatic test_full_load();
    reload_req = 1;
    step();
    reload_req = 0;
    total++;
    if ({ld_ready, cpu_rst, running, prog_len} !== {1'b1, 1'b1, 1'b0, 5'd0})
      $display("FAIL reload_run: got ld_ready/cpu_rst/running/len=%b/%b/%b/%0d want 1/1/0/0", ld_ready, cpu_rst, running, prog_len);
    else passed++;
    addr = 0; #1;
    total++;
    if ({opecode, imm} !== 8'h00) $display("FAIL load_fetch_mask: got %h want 00", {opecode, imm});
    else passed++;
    ld_valid = 1;
    for (int i = 0; i < 16; i++) begin
      ld_data = 8'(i << 4);
      step();
      if (i == 14) begin
        total++;
        if ({ld_ready, prog_len} !== {1'b1, 5'd15}) $display("FAIL full_15: got ld_ready/len=%b/%0d want 1/15", ld_ready, prog_len);
        else passed++;
      end
    end
    total++;
    if ({ld_ready, cpu_rst, prog_len} !== {1'b0, 1'b1, 5'd16})
      $display("FAIL full_armed: got ld_ready/cpu_rst/len=%b/%b/%0d want 0/1/16", ld_ready, cpu_rst, prog_len);
    else passed++;
    ld_data = 8'hAA;
    step();
    ld_valid = 0;
    total++;
    if (prog_len !== 5'd16) $display("FAIL full_17th_len: got %0d want 16", prog_len);
    else passed++;
    run_req = 1;
    step();
    run_req = 0;
    addr = 0; #1;
    total++;
    if ({opecode, imm} !== 8'h00) $display("FAIL full_fetch0: got %h want 00", {opecode, imm});
    else passed++;
    addr = 15; #1;
    total++;
    if ({opecode, imm} !== 8'hF0) $display("FAIL full_fetch15: got %h want f0", {opecode, imm});
    else passed++;
  endtask

  task automatic test_simultaneous();
    reload_req = 1;
    step();
    reload_req = 0;
    ld_valid = 1; ld_data = 8'h44; ld_last = 1;
    step();
    ld_valid = 0; ld_last = 0;
    total++;
    if ({ld_ready, prog_len} !== {1'b0, 5'd1}) $display("FAIL sim_armed: got ld_ready/len=%b/%0d want 0/1", ld_ready, prog_len);
    else passed++;
    run_req = 1; reload_req = 1;
    step();
    run_req = 0; reload_req = 0;
    total++;
    if ({cpu_rst, ld_ready, running, prog_len} !== {1'b1, 1'b1, 1'b0, 5'd0})
      $display("FAIL sim_both: got cpu_rst/ld_ready/running/len=%b/%b/%b/%0d want 1/1/0/0", cpu_rst, ld_ready, running, prog_len);
    else passed++;
    run_req = 1;
    step();
    run_req = 0;
    total++;
    if ({cpu_rst, running} !== 2'b01) $display("FAIL sim_run: got cpu_rst/running=%b/%b want 0/1", cpu_rst, running);
    else passed++;
    addr = 0; #1;
    total++;
    if ({opecode, imm} !== 8'h44) $display("FAIL sim_fetch0: got %h want 44", {opecode, imm});
    else passed++;
  endtask

  task automatic test_reload_mid_run();
    reload_req = 1;
    step();
    reload_req = 0;
    ld_valid = 1; ld_data = 8'h9F; ld_last = 1;
    step();
    ld_valid = 0; ld_last = 0;
    run_req = 1;
    step();
    run_req = 0;
    addr = 0; #1;
    total++;
    if ({opecode, imm} !== 8'h9F) $display("FAIL reload_fetch0: got %h want 9f", {opecode, imm});
    else passed++;
    addr = 1; #1;
    total++;
    if ({opecode, imm} !== 8'h10) $display("FAIL reload_fetch1: got %h want 10", {opecode, imm});
    else passed++;
    total++;
    if (prog_len !== 5'd1) $display("FAIL reload_len: got %0d want 1", prog_len);
    else passed++;
  endtask

  task automatic test_run_same_cycle();
    reload_req = 1;
    step();
    reload_req = 0;
    ld_valid = 1; ld_data = 8'h31; run_req = 1;
    step();
    ld_valid = 0; run_req = 0;
    addr = 0; #1;
    total++;
    if ({running, prog_len, opecode, imm} !== {1'b1, 5'd1, 8'h31})
      $display("FAIL same_cycle: got running/len/fetch=%b/%0d/%h want 1/1/31", running, prog_len, {opecode, imm});
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    reload_req = 1;
    step();
    reload_req = 0;
    ld_valid = 1;
    ld_data = 8'hAB; step();
    ld_data = 8'hCD; step();
    ld_data = 8'hEF; step();
    ld_valid = 0; ld_last = 1;
    step();
    ld_last = 0;
    total++;
    if ({ld_ready, prog_len} !== {1'b1, 5'd3}) $display("FAIL last_no_valid: got ld_ready/len=%b/%0d want 1/3", ld_ready, prog_len);
    else passed++;
    n_rst = 1;
    step();
    n_rst = 0;
    total++;
    if ({cpu_rst, ld_ready, running, prog_len} !== {1'b1, 1'b1, 1'b0, 5'd0})
      $display("FAIL midload_rst: got cpu_rst/ld_ready/running/len=%b/%b/%b/%0d want 1/1/0/0", cpu_rst, ld_ready, running, prog_len);
    else passed++;
    run_req = 1;
    step();
    run_req = 0;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1;
      total++;
      if ({opecode, imm} !== 8'h00) $display("FAIL midload_mem[%0d]: got %h want 00", a, {opecode, imm});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_short_load();
    test_full_load();
    test_simultaneous();
    test_reload_mid_run();
    test_run_same_cycle();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/td4_prog_loader.md
# td4_prog_loader

Program store and loader for the 4-bit CPU. It answers the CPU's instruction fetch: `addr` in, `opecode`/`imm` out. A host writes the program through a valid/ready byte interface while the block holds the CPU in reset. On a run request the block releases the CPU; on a reload request it stops the CPU and accepts a new program.

## Interface
Parameters:
- `DEPTH`, 16: number of program words; must equal 2**`AW`.
- `AW`, 4: fetch address width; matches the CPU `addr` width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, synchronous, active-high (1 = reset), despite the name.
- `addr`  in  AW  CPU fetch address (program counter).
- `opecode`  out  4  instruction upper nibble for `addr`.
- `imm`  out  4  instruction lower nibble for `addr`.
- `ld_valid`  in  1  host offers a program byte.
- `ld_data`  in  8  program byte: [7:4] = opecode, [3:0] = imm.
- `ld_last`  in  1  qualifies `ld_valid`: this byte is the final one.
- `ld_ready`  out  1  block accepts a byte this cycle.
- `run_req`  in  1  single-cycle pulse: start executing.
- `reload_req`  in  1  single-cycle pulse: stop the CPU and re-enter loading.
- `cpu_rst`  out  1  reset to the CPU, active-high; drives the CPU `n_rst`.
- `prog_len`  out  AW+1  number of bytes written in the current load (0..DEPTH).
- `running`  out  1  high in RUN.

## Operation
- Storage: DEPTH x 8 registers, plus write pointer `wptr` (AW+1 bits), plus a state register.
- Reset: all words = 0x00, `wptr` = 0, state = LOAD.
- Outputs during reset: `cpu_rst` = 1, `ld_ready` = 1, `prog_len` = 0, `running` = 0, `opecode` = 0, `imm` = 0.
- States:
  - LOAD: `ld_ready` = 1, `cpu_rst` = 1.
    - Accept on `ld_valid & ld_ready`: mem[wptr] <= `ld_data`, then `wptr` + 1.
    - Go to ARMED when the accepted byte has `ld_last` = 1, or when it is written to index DEPTH-1.
    - `run_req` in LOAD goes straight to RUN, keeping a partial program. A byte accepted in the same cycle is still written first.
  - ARMED: `ld_ready` = 0, `cpu_rst` = 1. `ld_valid` is ignored; no write occurs.
    - `run_req` goes to RUN.
    - `reload_req` goes to LOAD.
    - If both are high, `reload_req` wins.
  - RUN: `ld_ready` = 0, `cpu_rst` = 0, `running` = 1.
    - `reload_req` goes to LOAD. `run_req` is ignored.
- Entering LOAD from any state: `wptr` <= 0. Memory is not cleared; words beyond the new program keep their old contents.
- Fetch: `opecode`/`imm` = mem[`addr`], combinational, in RUN only. Both read 0 in LOAD and ARMED.
- `prog_len` = `wptr`. It saturates at DEPTH and never wraps to 0 within a load.
- `ld_last` without `ld_valid` has no effect.

## Timing
- `cpu_rst`, `running` and `ld_ready` decode directly from the registered state, with no logic from inputs. They change only at clock edges.
- Write latency: a byte accepted at edge N is readable from edge N on, once in RUN.
- Run handoff: `run_req` sampled at edge N moves the state to RUN at N. `cpu_rst` falls after N, so the CPU's first fetch after its reset is `addr` = 0 at edge N+1.
- Reload: `reload_req` at edge N moves the state to LOAD at N. `cpu_rst` = 1 and `ld_ready` = 1 after N. The CPU is reset synchronously at N+1, so its PC returns to 0.
- Fetch path: zero-cycle combinational read. There is no registered output on the fetch path.
- `n_rst` high mid-load or mid-run: full reset on the next edge. Memory is cleared and any in-progress handshake is dropped.

## Test plan
- Reset, then check outputs: `cpu_rst` = 1, `ld_ready` = 1, `prog_len` = 0, `opecode`/`imm` = 0 for every `addr` 0..15.
- Short load:
  - Stimulus: write 0x13, then 0x25 with `ld_last`, then pulse `run_req`.
  - Required: `prog_len` = 2; `cpu_rst` falls one edge after `run_req`.
  - Fetch `addr` 0 gives `opecode` = 1, `imm` = 3; `addr` 1 gives 2/5; `addr` 2 gives 0/0.
- Full load without `ld_last`:
  - Stimulus: write 16 bytes 0x00..0xF0 (0x00, 0x10, …, 0xF0).
  - Required: state goes to ARMED after the 16th byte; `ld_ready` = 0; `prog_len` = 16.
  - A 17th `ld_valid` is not written: `addr` 0 still reads 0/0 after run.
- Simultaneous requests in ARMED:
  - `run_req` and `reload_req` in the same cycle: state goes to LOAD and `cpu_rst` stays 1.
  - A following `run_req` alone: state goes to RUN.
- Reload mid-run:
  - Stimulus: in RUN, pulse `reload_req`, write 0x9F with `ld_last`, then `run_req`.
  - Required: `addr` 0 reads 9/F; `addr` 1 keeps its old contents; `prog_len` = 1.
- Reset mid-load:
  - Stimulus: after 3 bytes, assert `n_rst` for 1 cycle.
  - Required: `prog_len` = 0, memory all zero, state = LOAD.
